// File: rtl/ysyx_idu_decode.sv
// RV32I/RV32E decode stage: one skid-free pipeline register between IFU and EXU.
// Illegal encodings still flow down the pipe as a SYSTEM bundle so EXU can trap.
module ysyx_idu_decode #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NR_REG = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prev_valid,
    output logic              ready_o,
    input  logic [31:0]       inst_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush,
    input  logic              next_ready,
    output logic              valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [4:0]        rd_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [2:0]        op_type_o,
    output logic [3:0]        alu_op_o,
    output logic              alu_src_imm_o,
    output logic [2:0]        funct3_o,
    output logic              wen_o,
    output logic              sys_o,
    output logic              illegal_o
);

    localparam logic [4:0] OpcLoad    = 5'b00000;
    localparam logic [4:0] OpcMiscMem = 5'b00011;
    localparam logic [4:0] OpcOpImm   = 5'b00100;
    localparam logic [4:0] OpcAuipc   = 5'b00101;
    localparam logic [4:0] OpcStore   = 5'b01000;
    localparam logic [4:0] OpcOp      = 5'b01100;
    localparam logic [4:0] OpcLui     = 5'b01101;
    localparam logic [4:0] OpcBranch  = 5'b11000;
    localparam logic [4:0] OpcJalr    = 5'b11001;
    localparam logic [4:0] OpcJal     = 5'b11011;
    localparam logic [4:0] OpcSystem  = 5'b11100;

    localparam logic [2:0] OpAlu    = 3'd0;
    localparam logic [2:0] OpLoad   = 3'd1;
    localparam logic [2:0] OpStore  = 3'd2;
    localparam logic [2:0] OpBranch = 3'd3;
    localparam logic [2:0] OpJal    = 3'd4;
    localparam logic [2:0] OpJalr   = 3'd5;
    localparam logic [2:0] OpLui    = 3'd6;
    localparam logic [2:0] OpSys    = 3'd7;

    localparam logic [3:0] AluAdd = 4'd0;

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'd0:    op = alt ? 4'd1 : 4'd0;
            3'd1:    op = 4'd2;
            3'd2:    op = 4'd3;
            3'd3:    op = 4'd4;
            3'd4:    op = 4'd5;
            3'd5:    op = alt ? 4'd7 : 4'd6;
            3'd6:    op = 4'd8;
            default: op = 4'd9;
        endcase
        return op;
    endfunction

    logic [4:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1_f, rs2_f, rd_f;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = inst_i[6:2];
    assign f3     = inst_i[14:12];
    assign f7     = inst_i[31:25];
    assign rs1_f  = inst_i[19:15];
    assign rs2_f  = inst_i[24:20];
    assign rd_f   = inst_i[11:7];
    assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b  = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u  = {inst_i[31:12], 12'b0};
    assign imm_j  = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_q;
    logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [2:0]        op_q, op_d;
    logic [3:0]        alu_q, alu_d;
    logic              src_q, src_d;
    logic [2:0]        f3_q, f3_d;
    logic              wen_q, wen_d;
    logic              sys_q, sys_d;
    logic              ill_q, ill_d;

    logic [31:0] imm32;
    logic        wen_raw;
    logic        bad;
    logic        rs1_zimm;
    logic        reg_bad;
    logic        accept;

    assign ready_o = !valid_q || next_ready;
    assign accept  = prev_valid && ready_o && !flush;

    always_comb begin
        rs1_d    = '0;
        rs2_d    = '0;
        rd_d     = '0;
        imm32    = '0;
        op_d     = OpAlu;
        alu_d    = AluAdd;
        src_d    = 1'b0;
        f3_d     = f3;
        wen_raw  = 1'b0;
        sys_d    = 1'b0;
        bad      = 1'b0;
        rs1_zimm = 1'b0;

        case (opcode)
            OpcLui: begin
                rd_d = rd_f; imm32 = imm_u; op_d = OpLui; src_d = 1'b1; wen_raw = 1'b1;
            end
            OpcAuipc: begin
                rd_d = rd_f; imm32 = imm_u; op_d = OpSys; src_d = 1'b1; wen_raw = 1'b1;
            end
            OpcJal: begin
                rd_d = rd_f; imm32 = imm_j; op_d = OpJal; src_d = 1'b1; wen_raw = 1'b1;
            end
            OpcJalr: begin
                rs1_d = rs1_f; rd_d = rd_f; imm32 = imm_i; op_d = OpJalr;
                src_d = 1'b1; wen_raw = 1'b1;
                bad = (f3 != 3'd0);
            end
            OpcBranch: begin
                rs1_d = rs1_f; rs2_d = rs2_f; imm32 = imm_b; op_d = OpBranch;
                bad = (f3 == 3'd2) || (f3 == 3'd3);
            end
            OpcLoad: begin
                rs1_d = rs1_f; rd_d = rd_f; imm32 = imm_i; op_d = OpLoad;
                src_d = 1'b1; wen_raw = 1'b1;
                bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            OpcStore: begin
                rs1_d = rs1_f; rs2_d = rs2_f; imm32 = imm_s; op_d = OpStore; src_d = 1'b1;
                bad = (f3 > 3'd2);
            end
            OpcOpImm: begin
                rs1_d = rs1_f; rd_d = rd_f; imm32 = imm_i; src_d = 1'b1; wen_raw = 1'b1;
                alu_d = alu_of(f3, (f3 == 3'd5) && f7[5]);
                // Shift-immediates carry funct7 in the upper immediate bits
                bad = ((f3 == 3'd1) && (f7 != 7'h00)) ||
                      ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
            end
            OpcOp: begin
                rs1_d = rs1_f; rs2_d = rs2_f; rd_d = rd_f; wen_raw = 1'b1;
                alu_d = alu_of(f3, f7[5]);
                bad = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
            end
            OpcMiscMem: begin
                imm32 = imm_i;
                bad   = (f3 != 3'd0);
            end
            OpcSystem: begin
                imm32 = imm_i; op_d = OpSys; sys_d = 1'b1;
                if (f3 == 3'd0) begin
                    bad = !((inst_i == 32'h0000_0073) || (inst_i == 32'h0010_0073) ||
                            (inst_i == 32'h3020_0073));
                end else if (f3 == 3'd4) begin
                    bad = 1'b1;
                end else begin
                    rs1_d = rs1_f; rd_d = rd_f; wen_raw = 1'b1;
                    rs1_zimm = f3[2];
                end
            end
            default: bad = 1'b1;
        endcase

        // csrr*i reuses the rs1 field as a 5-bit immediate, so it is not range-checked
        reg_bad = ((32'(rs1_d) >= NR_REG) && !rs1_zimm) ||
                  (32'(rs2_d) >= NR_REG) || (32'(rd_d) >= NR_REG);
        ill_d   = bad || reg_bad || (inst_i[1:0] != 2'b11);

        if (ill_d) begin
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
            imm32   = '0;
            op_d    = OpSys;
            alu_d   = AluAdd;
            src_d   = 1'b0;
            f3_d    = '0;
            wen_raw = 1'b0;
            sys_d   = 1'b1;
        end

        wen_d = wen_raw && (rd_d != 5'd0);
        imm_d = DATA_W'($signed(imm32));
    end

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (next_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            op_q    <= '0;
            alu_q   <= '0;
            src_q   <= 1'b0;
            f3_q    <= '0;
            wen_q   <= 1'b0;
            sys_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                pc_q  <= pc_i;
                rs1_q <= rs1_d;
                rs2_q <= rs2_d;
                rd_q  <= rd_d;
                imm_q <= imm_d;
                op_q  <= op_d;
                alu_q <= alu_d;
                src_q <= src_d;
                f3_q  <= f3_d;
                wen_q <= wen_d;
                sys_q <= sys_d;
                ill_q <= ill_d;
            end
        end
    end

    assign valid_o       = valid_q;
    assign pc_o          = pc_q;
    assign rs1_o         = rs1_q;
    assign rs2_o         = rs2_q;
    assign rd_o          = rd_q;
    assign imm_o         = imm_q;
    assign op_type_o     = op_q;
    assign alu_op_o      = alu_q;
    assign alu_src_imm_o = src_q;
    assign funct3_o      = f3_q;
    assign wen_o         = wen_q;
    assign sys_o         = sys_q;
    assign illegal_o     = ill_q;

endmodule

// File: tb/tb_ysyx_idu_decode.sv
// Bench for ysyx_idu_decode: ISA-level reference decode plus handshake model, checked
// every negedge, with literal spot checks on the directed vectors.
module tb_ysyx_idu_decode;

    localparam int unsigned NR = 16;

    logic        clk = 1'b0;
    logic        rst, prev_valid, flush, next_ready;
    logic [31:0] inst_i, pc_i;
    logic        ready_o, valid_o, alu_src_imm_o, wen_o, sys_o, illegal_o;
    logic [31:0] pc_o, imm_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [2:0]  op_type_o, funct3_o;
    logic [3:0]  alu_op_o;

    ysyx_idu_decode #(.ADDR_W(32), .DATA_W(32), .NR_REG(NR)) dut (
        .clk(clk), .rst(rst), .prev_valid(prev_valid), .ready_o(ready_o), .inst_i(inst_i),
        .pc_i(pc_i), .flush(flush), .next_ready(next_ready), .valid_o(valid_o), .pc_o(pc_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .imm_o(imm_o), .op_type_o(op_type_o),
        .alu_op_o(alu_op_o), .alu_src_imm_o(alu_src_imm_o), .funct3_o(funct3_o),
        .wen_o(wen_o), .sys_o(sys_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [2:0]  op;
        logic [3:0]  alu;
        logic        src;
        logic [2:0]  f3;
        logic        wen, sys, ill;
    } bundle_t;

    int n_checks = 0;
    int n_fail   = 0;
    int n_hand   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written from the ISA tables, not from the RTL structure.
    function automatic bundle_t ref_decode(input logic [31:0] in, input logic [31:0] pc);
        bundle_t b;
        int f3, f7, v, hi;
        int alu_tbl [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        logic ok;
        logic [31:0] ii, is, ib, iu, ij;
        b = '0;
        b.pc = pc;
        f3 = int'(in[14:12]);
        f7 = int'(in[31:25]);
        ii = $signed(in) >>> 20;
        is = {ii[31:5], in[11:7]};
        iu = {in[31:12], 12'b0};
        v = int'({in[31], in[7], in[30:25], in[11:8], 1'b0});
        if (in[31]) v -= 8192;
        ib = v;
        v = int'({in[31], in[19:12], in[20], in[30:21], 1'b0});
        if (in[31]) v -= (1 << 21);
        ij = v;
        ok = 1'b1;
        hi = 0;
        b.f3 = in[14:12];
        case (in[6:0])
            7'h37: begin b.rd = in[11:7]; b.imm = iu; b.op = 6; b.src = 1; end
            7'h17: begin b.rd = in[11:7]; b.imm = iu; b.op = 7; b.src = 1; end
            7'h6F: begin b.rd = in[11:7]; b.imm = ij; b.op = 4; b.src = 1; end
            7'h67: begin
                b.rd = in[11:7]; b.rs1 = in[19:15]; b.imm = ii; b.op = 5; b.src = 1;
                ok = (f3 == 0);
            end
            7'h63: begin
                b.rs1 = in[19:15]; b.rs2 = in[24:20]; b.imm = ib; b.op = 3;
                ok = (f3 != 2) && (f3 != 3);
            end
            7'h03: begin
                b.rd = in[11:7]; b.rs1 = in[19:15]; b.imm = ii; b.op = 1; b.src = 1;
                ok = (f3 <= 2) || (f3 == 4) || (f3 == 5);
            end
            7'h23: begin
                b.rs1 = in[19:15]; b.rs2 = in[24:20]; b.imm = is; b.op = 2; b.src = 1;
                ok = (f3 <= 2);
            end
            7'h13: begin
                b.rd = in[11:7]; b.rs1 = in[19:15]; b.imm = ii; b.src = 1;
                b.alu = 4'(alu_tbl[f3] + ((f3 == 5 && f7 == 32) ? 1 : 0));
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) ok = (f7 == 0) || (f7 == 32);
            end
            7'h33: begin
                b.rd = in[11:7]; b.rs1 = in[19:15]; b.rs2 = in[24:20];
                b.alu = 4'(alu_tbl[f3] + ((f7 == 32) ? 1 : 0));
                ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
            end
            7'h0F: begin b.imm = ii; ok = (f3 == 0); end
            7'h73: begin
                b.imm = ii; b.op = 7; b.sys = 1;
                if (f3 == 0) ok = (in == 32'h73) || (in == 32'h0010_0073) || (in == 32'h3020_0073);
                else if (f3 == 4) ok = 1'b0;
                else begin
                    b.rd = in[11:7];
                    b.rs1 = in[19:15];
                    if (f3 < 4 && int'(b.rs1) > hi) hi = int'(b.rs1);
                end
            end
            default: ok = 1'b0;
        endcase
        if (in[6:0] != 7'h73) begin
            if (int'(b.rs1) > hi) hi = int'(b.rs1);
        end
        if (int'(b.rs2) > hi) hi = int'(b.rs2);
        if (int'(b.rd) > hi) hi = int'(b.rd);
        if (hi >= int'(NR)) ok = 1'b0;
        // Writers of rd: everything with an rd field except branches/stores/fence/ecall
        b.wen = (b.rd != 0);
        if (!ok) begin
            b = '0;
            b.pc = pc; b.op = 7; b.sys = 1; b.ill = 1;
        end
        return b;
    endfunction

    // Handshake model
    logic    m_on = 1'b0;
    logic    m_valid = 1'b0;
    logic    m_zero = 1'b0;
    bundle_t m_b = '0;
    logic [31:0] sent_q [$];

    always @(negedge clk) begin
        bundle_t d;
        logic acc, hand;
        if (m_on) begin
            d = '{pc_o, rs1_o, rs2_o, rd_o, imm_o, op_type_o, alu_op_o, alu_src_imm_o,
                  funct3_o, wen_o, sys_o, illegal_o};
            check("valid_o", 32'(valid_o), 32'(m_valid));
            check("ready_o", 32'(ready_o), 32'(!m_valid || next_ready));
            if (m_valid || m_zero) begin
                check("pc_o", d.pc, m_b.pc);
                check("rs1_o", 32'(d.rs1), 32'(m_b.rs1));
                check("rs2_o", 32'(d.rs2), 32'(m_b.rs2));
                check("rd_o", 32'(d.rd), 32'(m_b.rd));
                check("imm_o", d.imm, m_b.imm);
                check("op_type_o", 32'(d.op), 32'(m_b.op));
                check("alu_op_o", 32'(d.alu), 32'(m_b.alu));
                check("alu_src_imm_o", 32'(d.src), 32'(m_b.src));
                check("funct3_o", 32'(d.f3), 32'(m_b.f3));
                check("wen_o", 32'(d.wen), 32'(m_b.wen));
                check("sys_o", 32'(d.sys), 32'(m_b.sys));
                check("illegal_o", 32'(d.ill), 32'(m_b.ill));
            end
        end
        acc  = prev_valid && (!m_valid || next_ready) && !flush;
        hand = m_valid && next_ready;
        if (rst) begin
            m_on = 1'b1; m_valid = 1'b0; m_zero = 1'b1; m_b = '0;
            sent_q.delete();
        end else if (m_on) begin
            if (flush) begin
                m_valid = 1'b0; m_zero = 1'b0;
                sent_q.delete();
            end else begin
                if (hand) begin
                    n_hand++;
                    if (sent_q.size() == 0) check("handoff_order", pc_o, 32'hDEAD_BEEF);
                    else check("handoff_order", pc_o, sent_q.pop_front());
                end
                if (acc) begin
                    m_b = ref_decode(inst_i, pc_i); m_valid = 1'b1; m_zero = 1'b0;
                    sent_q.push_back(pc_i);
                end else if (hand) begin
                    m_valid = 1'b0; m_zero = 1'b0;
                end
            end
        end
    end

    task automatic drive(input logic pv, input logic [31:0] in, input logic [31:0] pc,
                         input logic nr, input logic fl);
        prev_valid = pv; inst_i = in; pc_i = pc; next_ready = nr; flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic one(input logic [31:0] in, input logic [31:0] pc);
        drive(1'b1, in, pc, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    logic [31:0] mix [10] = '{32'h0050_0093, 32'h0020_81B3, 32'h4020_81B3, 32'h4020_D1B3,
                              32'h4030_D213, 32'h0081_2283, 32'h0051_2623, 32'h0100_00EF,
                              32'h0000_8067, 32'h1234_5337};
    logic [31:0] odd [6]  = '{32'h0000_0073, 32'h0220_81B3, 32'h0FF0_000F, 32'h3001_10F3,
                              32'h0000_B003, 32'h0200_9093};

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        // reset state
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_imm", imm_o, 32'd0);
        check("rst_illegal", 32'(illegal_o), 32'd0);

        // addi x1,x0,5
        one(32'h0050_0093, 32'h8000_0000);
        check("addi_valid", 32'(valid_o), 32'd1);
        check("addi_rd", 32'(rd_o), 32'd1);
        check("addi_rs1", 32'(rs1_o), 32'd0);
        check("addi_imm", imm_o, 32'd5);
        check("addi_op", 32'(op_type_o), 32'd0);
        check("addi_alu", 32'(alu_op_o), 32'd0);
        check("addi_src", 32'(alu_src_imm_o), 32'd1);
        check("addi_wen", 32'(wen_o), 32'd1);
        check("addi_ill", 32'(illegal_o), 32'd0);

        // bne x1,x2,-4
        one(32'hFE20_9EE3, 32'h8000_0004);
        check("bne_op", 32'(op_type_o), 32'd3);
        check("bne_imm", imm_o, 32'hFFFF_FFFC);
        check("bne_f3", 32'(funct3_o), 32'd1);
        check("bne_wen", 32'(wen_o), 32'd0);
        check("bne_rs2", 32'(rs2_o), 32'd2);
        step();

        // stall: held bundle stable while a new instruction waits
        drive(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h00A0_0113, 32'h104, 1'b0, 1'b0);
        repeat (3) begin
            step();
            check("stall_ready", 32'(ready_o), 32'd0);
            check("stall_pc", pc_o, 32'h100);
        end
        drive(1'b1, 32'h00A0_0113, 32'h104, 1'b1, 1'b0);
        step();
        check("release_pc", pc_o, 32'h104);
        check("release_imm", imm_o, 32'd10);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        check("drain_valid", 32'(valid_o), 32'd0);

        // flush while stalled, then 10 back-to-back accepts
        drive(1'b1, 32'h0050_0093, 32'h200, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h00A0_0113, 32'h204, 1'b0, 1'b1);
        step();
        check("flush_valid", 32'(valid_o), 32'd0);
        n_hand = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, mix[i], 32'h300 + 32'(4 * i), 1'b1, 1'b0);
            step();
            check("b2b_valid", 32'(valid_o), 32'd1);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        step();
        check("b2b_handoffs", 32'(n_hand), 32'd10);

        // RV32E range and illegal encodings
        one(32'h0100_0813, 32'h400);
        check("x16_ill", 32'(illegal_o), 32'd1);
        check("x16_wen", 32'(wen_o), 32'd0);
        check("x16_op", 32'(op_type_o), 32'd7);
        check("x16_sys", 32'(sys_o), 32'd1);
        one(32'h0000_0000, 32'h404);
        check("zero_ill", 32'(illegal_o), 32'd1);
        for (int i = 0; i < 6; i++) one(odd[i], 32'h500 + 32'(4 * i));
        step();

        // reset together with flush and a pending instruction
        drive(1'b1, 32'h0050_0093, 32'h600, 1'b1, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("rstflush_valid", 32'(valid_o), 32'd0);
        check("rstflush_pc", pc_o, 32'd0);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
